// File: rtl/mem_dma_arb_pkg.sv
// rtl/mem_dma_arb_pkg.sv - shared types and defaults for the console-bus DMA arbiter
package mem_dma_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    HOLD   = 3'd4,
    ACK    = 3'd5
  } state_t;

  localparam logic [1:0] TGT_PRG = 2'd0;
  localparam logic [1:0] TGT_CHR = 2'd1;
  localparam logic [1:0] TGT_SRM = 2'd2;
  localparam logic [1:0] TGT_RSV = 2'd3;

  localparam int STROBE_LEN_DEF = 4;
  localparam int FREE_TMO_DEF   = 100;

endpackage

// File: rtl/mem_dma_arb_m2_phase_det.sv
// rtl/mem_dma_arb_m2_phase_det.sv - M2 synchroniser, edge detect and stopped-clock timeout
module m2_phase_det
  import mem_dma_arb_pkg::*;
#(
  parameter int FREE_TMO = FREE_TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic m2,
  output logic fall,
  output logic rise,
  output logic free_mode
);

  localparam int GW = $clog2(FREE_TMO + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(FREE_TMO);

  logic [1:0]    m2_s;
  logic [GW-1:0] gap;
  logic          fall_c;
  logic          rise_c;

  assign fall_c    = m2_s[1] & ~m2_s[0];
  assign rise_c    = ~m2_s[1] & m2_s[0];
  assign free_mode = (gap == GAP_MAX);

  // Edge pulses are registered for the FSM; the gap counter clears from the raw
  // detect so free_mode is already low when the FSM sees the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_s <= 2'b00;
      gap  <= '0;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      m2_s <= {m2_s[0], m2};
      fall <= fall_c;
      rise <= rise_c;
      if (fall_c || rise_c) begin
        gap <= '0;
      end else if (gap != GAP_MAX) begin
        gap <= gap + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_dma_arb.sv
// rtl/mem_dma_arb.sv - DMA access arbiter slotting memory cycles into the M2 low phase
module mem_dma_arb
  import mem_dma_arb_pkg::*;
#(
  parameter int STROBE_LEN = STROBE_LEN_DEF,
  parameter int FREE_TMO   = FREE_TMO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m2,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [1:0]  dma_tgt,
  input  logic [22:0] dma_addr,
  input  logic [7:0]  dma_wdat,
  input  logic [7:0]  mem_rdat,
  output logic        grant,
  output logic        req_prg,
  output logic        req_chr,
  output logic        req_srm,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_wdat,
  output logic [7:0]  dma_rdat,
  output logic        dma_ack,
  output logic        free_mode
);

  localparam int CW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_LEN - 1);

  state_t        state;
  state_t        state_n;
  logic          we_l;
  logic [1:0]    tgt_l;
  logic [22:0]   addr_l;
  logic [7:0]    wdat_l;
  logic [CW-1:0] cnt;
  logic          fall;
  logic          rise;
  logic          abort;
  logic          capture;

  m2_phase_det #(.FREE_TMO(FREE_TMO)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .m2        (m2),
    .fall      (fall),
    .rise      (rise),
    .free_mode (free_mode)
  );

  // An M2 rise before the strobe finishes means the console is about to drive the bus.
  assign abort   = rise && !free_mode && (state == SETUP || state == ACCESS);
  assign capture = (state == ACCESS) && (cnt == CNT_LAST) && !we_l && !abort;

  assign req_prg  = grant && (tgt_l == TGT_PRG || tgt_l == TGT_RSV);
  assign req_chr  = grant && (tgt_l == TGT_CHR);
  assign req_srm  = grant && (tgt_l == TGT_SRM);
  assign mem_addr = addr_l;
  assign mem_wdat = wdat_l;

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    mem_ce  = 1'b0;
    mem_oe  = 1'b0;
    mem_we  = 1'b0;
    dma_ack = 1'b0;
    case (state)
      IDLE: begin
        if (dma_req) state_n = SYNC;
      end
      SYNC: begin
        if (fall || free_mode) state_n = SETUP;
      end
      SETUP: begin
        grant   = 1'b1;
        mem_ce  = 1'b1;
        state_n = abort ? SYNC : ACCESS;
      end
      ACCESS: begin
        grant  = 1'b1;
        mem_ce = 1'b1;
        mem_oe = ~we_l;
        mem_we = we_l;
        if (abort) begin
          state_n = SYNC;
        end else if (cnt == CNT_LAST) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        grant   = 1'b1;
        mem_ce  = 1'b1;
        state_n = ACK;
      end
      ACK: begin
        dma_ack = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_l     <= 1'b0;
      tgt_l    <= TGT_PRG;
      addr_l   <= '0;
      wdat_l   <= '0;
      cnt      <= '0;
      dma_rdat <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && dma_req) begin
        we_l   <= dma_we;
        tgt_l  <= dma_tgt;
        addr_l <= dma_addr;
        wdat_l <= dma_wdat;
      end
      cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
      if (capture) dma_rdat <= mem_rdat;
    end
  end

endmodule

// File: doc/mem_dma_arb.md
MEM_DMA_ARB -- requirements
Module: mem_dma_arb

Interface
REQ-001 SHALL have parameter STROBE_LEN, default 4, giving the number of clk cycles the OE/WE strobe is held.
REQ-002 SHALL have parameter FREE_TMO, default 100, giving the number of clk cycles without an m2 edge before the block enters free mode.
REQ-003 SHALL have port clk, input, 1 bit: 50 MHz system clock; sole clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port m2, input, 1 bit: raw console M2; asynchronous to clk.
REQ-006 SHALL have port dma_req, input, 1 bit: transfer request; held high until dma_ack.
REQ-007 SHALL have port dma_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port dma_tgt, input, 2 bits: 0 = PRG, 1 = CHR, 2 = SRM; 3 is reserved and treated as PRG.
REQ-009 SHALL have port dma_addr, input, 23 bits: memory byte address.
REQ-010 SHALL have port dma_wdat, input, 8 bits: write data.
REQ-011 SHALL have port mem_rdat, input, 8 bits: data returned by the selected memory.
REQ-012 SHALL have port grant, output, 1 bit: steers the memory muxes to the DMA path.
REQ-013 SHALL have port req_prg, req_chr and req_srm, outputs, 1 bit each: one-hot decode of the latched tgt, valid only while grant is high.
REQ-014 SHALL have port mem_ce, mem_oe and mem_we, outputs, 1 bit each: active-high strobes.
REQ-015 SHALL have port mem_addr, output, 23 bits, and mem_wdat, output, 8 bits: the latched address and write data.
REQ-016 SHALL have port dma_rdat, output, 8 bits: captured read data.
REQ-017 SHALL have port dma_ack, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port free_mode, output, 1 bit: high when M2 is considered stopped.

Function
REQ-019 SHALL synchronise m2 through two flops, m2_s[1:0]; a falling edge is detected when the prior sample is 1 and the new sample is 0, and rising edges are detected the same way.
REQ-020 SHALL run an edge-gap counter that is cleared on any m2 edge, increments otherwise, and saturates at FREE_TMO.
REQ-021 SHALL assert free_mode while the edge-gap counter equals FREE_TMO, and SHALL drop free_mode on the cycle after the next m2 edge.
REQ-022 SHALL use states IDLE, SYNC, SETUP, ACCESS, HOLD and ACK.
REQ-023 In IDLE, when dma_req is high, SHALL latch dma_we, dma_tgt, dma_addr and dma_wdat, then go to SYNC.
REQ-024 In SYNC, on a detected m2 falling edge or while free_mode is high, SHALL go to SETUP.
REQ-025 In SETUP, for 1 cycle, SHALL hold grant=1, the req_* line for the latched target =1, mem_ce=1, mem_oe=0, mem_we=0, with mem_addr and mem_wdat valid.
REQ-026 In ACCESS, for STROBE_LEN cycles, SHALL hold grant=1 and mem_ce=1, with mem_oe = !we_l and mem_we = we_l.
REQ-027 On a read, SHALL capture mem_rdat into dma_rdat on the last ACCESS cycle.
REQ-028 In HOLD, for 1 cycle, SHALL keep grant=1 and mem_ce=1 with mem_oe=0 and mem_we=0, so address and data are held after the strobe.
REQ-029 In ACK, for 1 cycle, SHALL pulse dma_ack=1 with grant=0, then return to IDLE.
REQ-030 SHALL complete the SETUP-to-HOLD window in STROBE_LEN+2 clk cycles (6 at the default), which fits inside the M2 low phase.
REQ-031 SHALL sample a new request no earlier than the first IDLE cycle after ACK, giving back-to-back requests a minimum spacing of one m2 period when free_mode is low.
REQ-032 If an m2 rising edge is detected in SETUP or ACCESS while free_mode is low, SHALL abort the access.
REQ-033 On abort, SHALL drop all strobes and grant on the next cycle, issue no ack, keep dma_rdat unchanged, and return to SYNC to retry.
REQ-034 SHALL never assert mem_oe and mem_we together.
REQ-035 SHALL never assert mem_we outside ACCESS.
REQ-036 SHALL keep exactly one req_* line high while grant is high, and all req_* lines low otherwise.
REQ-037 SHALL ignore changes on dma_* inputs after the latch in IDLE.
REQ-038 SHALL not re-latch dma_req while it is still high during ACK.
REQ-039 If free_mode falls while in SYNC, SHALL keep waiting for an m2 falling edge.

Reset
REQ-040 When rst=1 at a clk edge, SHALL go to IDLE and clear grant, req_*, mem_ce, mem_oe, mem_we, dma_ack, dma_rdat, the latches and m2_s.
REQ-041 SHALL clear the edge-gap counter to 0 on reset, so free_mode=0.
REQ-042 SHALL take effect mid-operation from any state, with strobes low on the cycle after rst is sampled and no dma_ack issued.

Structure
REQ-043 SHALL place the state enum, the tgt encodings (TGT_PRG, TGT_CHR, TGT_SRM) and the default STROBE_LEN and FREE_TMO in the shared package.
REQ-044 SHALL implement the m2 synchroniser, edge detect and edge-gap counter as one sub-module, m2_phase_det, with outputs fall, rise and free_mode; the FSM stays in mem_dma_arb.

Verification
REQ-045 Bench SHALL cover a read at m2 = 1.79 MHz: dma_req with addr 0x000123 and tgt PRG -> SETUP follows the next m2 fall by 3 clk (2 sync + 1); mem_oe high for 4 cycles; dma_rdat = the memory byte 0xA5; one dma_ack pulse.
REQ-046 Bench SHALL cover an SRM write: dma_we=1, wdat 0x5A -> mem_we high for exactly 4 cycles; mem_addr and mem_wdat stable from SETUP through HOLD; req_srm=1 only while grant=1; mem_oe stays 0.
REQ-047 Bench SHALL cover free mode: m2 held low for 150 cycles -> free_mode=1 at cycle 102; a request then completes SYNC-to-ACK in 8 cycles with no edge; toggling m2 again clears free_mode.
REQ-048 Bench SHALL cover abort: force an m2 rise during ACCESS cycle 2 -> strobes and grant low on the next cycle; no ack; the retry succeeds after the next m2 fall with the same address.
REQ-049 Bench SHALL cover reset mid-access: rst asserted in ACCESS -> all outputs 0 on the next cycle; state IDLE; dma_ack never pulses; a new request after reset completes normally.
REQ-050 Bench SHALL cover back-to-back requests: 3 consecutive reads -> 3 acks, each access starting on a separate m2 falling edge; no overlap of mem_oe and mem_we at any time.
